// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux over the enabled channels. Each select change is followed
// by a programmable settle time, then y_in is captured; a frame is emitted
// once every enabled channel has been captured.
module mux_scan_ctrl #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [3:0]          ch_mask,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                y_in,
  output logic [1:0]          s,
  output logic                busy,
  output logic                sample_valid,
  output logic [1:0]          sample_ch,
  output logic                sample_data,
  output logic                frame_valid,
  output logic [3:0]          frame_data
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [3:0]          acc_q, acc_d;
  logic [1:0]          s_q, s_d;
  logic                busy_q, busy_d;
  logic                sv_q, sv_d;
  logic [1:0]          sch_q, sch_d;
  logic                sd_q, sd_d;
  logic                fv_q, fv_d;
  logic [3:0]          fd_q, fd_d;
  logic [3:0]          acc_next;
  logic [2:0]          nxt;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_ch = 2'(i);
  endfunction

  // bit 2 flags that a higher enabled channel exists, bits 1:0 give its index
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    next_ch = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, 2'(i)};
  endfunction

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    s_d      = s_q;
    busy_d   = busy_q;
    sv_d     = 1'b0;
    sch_d    = sch_q;
    sd_d     = sd_q;
    fv_d     = 1'b0;
    fd_d     = fd_q;
    acc_next = acc_q;
    nxt      = 3'b000;

    case (state_q)
      IDLE: begin
        if (start && (ch_mask != 4'd0)) begin
          mask_d   = ch_mask;
          settle_d = settle;
          s_d      = lowest_ch(ch_mask);
          cnt_d    = settle;
          acc_d    = 4'd0;
          busy_d   = 1'b1;
          state_d  = (settle == '0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q > SETTLE_W'(1)) begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        acc_next[s_q] = y_in;
        acc_d         = acc_next;
        sv_d          = 1'b1;
        sch_d         = s_q;
        sd_d          = y_in;
        nxt           = next_ch(mask_q, s_q);
        if (nxt[2]) begin
          s_d     = nxt[1:0];
          cnt_d   = settle_q;
          state_d = (settle_q == '0) ? CAPTURE : SETTLE;
        end else begin
          fv_d = 1'b1;
          fd_d = acc_next & mask_q;
          // Back-to-back frame: new configuration is latched on the same edge
          if (continuous && (ch_mask != 4'd0)) begin
            mask_d   = ch_mask;
            settle_d = settle;
            s_d      = lowest_ch(ch_mask);
            cnt_d    = settle;
            acc_d    = 4'd0;
            state_d  = (settle == '0) ? CAPTURE : SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a start seen in IDLE
    if (abort) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      mask_d   = mask_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      s_d      = s_q;
      sv_d     = 1'b0;
      sch_d    = sch_q;
      sd_d     = sd_q;
      fv_d     = 1'b0;
      fd_d     = fd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= 4'd0;
      settle_q <= '0;
      cnt_q    <= '0;
      acc_q    <= 4'd0;
      s_q      <= 2'd0;
      busy_q   <= 1'b0;
      sv_q     <= 1'b0;
      sch_q    <= 2'd0;
      sd_q     <= 1'b0;
      fv_q     <= 1'b0;
      fd_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      sv_q     <= sv_d;
      sch_q    <= sch_d;
      sd_q     <= sd_d;
      fv_q     <= fv_d;
      fd_q     <= fd_d;
    end
  end

  assign s            = s_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign sample_data  = sd_q;
  assign frame_valid  = fv_q;
  assign frame_data   = fd_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a frame-level model.
module tb_mux_scan_ctrl;

  localparam int SETTLE_W = 4;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic                continuous;
  logic [3:0]          ch_mask;
  logic [SETTLE_W-1:0] settle;
  logic                y_in;
  logic [1:0]          s;
  logic                busy;
  logic                sample_valid;
  logic [1:0]          sample_ch;
  logic                sample_data;
  logic                frame_valid;
  logic [3:0]          frame_data;

  mux_scan_ctrl #(.SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .continuous(continuous), .ch_mask(ch_mask), .settle(settle),
    .y_in(y_in), .s(s), .busy(busy), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data),
    .frame_valid(frame_valid), .frame_data(frame_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: counts edges since the last select change
  bit       m_busy;
  int       m_ch, m_since, m_settle;
  bit [3:0] m_mask, m_acc, m_fd;
  bit       m_sv, m_sd, m_fv;
  int       m_sch;

  task automatic m_reset();
    m_busy = 0; m_ch = 0; m_since = 0; m_settle = 0;
    m_mask = 0; m_acc = 0; m_fd = 0;
    m_sv = 0; m_sd = 0; m_fv = 0; m_sch = 0;
  endtask

  task automatic m_launch();
    m_mask   = ch_mask;
    m_settle = int'(settle);
    for (int i = 3; i >= 0; i--) if (ch_mask[i]) m_ch = i;
    m_since  = 0;
    m_acc    = 0;
    m_busy   = 1;
  endtask

  task automatic m_edge();
    int nxt;
    m_sv = 0;
    m_fv = 0;
    if (abort) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start && ch_mask != 0) m_launch();
    end else begin
      m_since++;
      if (m_since == m_settle + 1) begin
        m_acc[m_ch] = y_in;
        m_sv  = 1;
        m_sch = m_ch;
        m_sd  = y_in;
        nxt   = -1;
        for (int i = 3; i > m_ch; i--) if (m_mask[i]) nxt = i;
        if (nxt >= 0) begin
          m_ch    = nxt;
          m_since = 0;
        end else begin
          m_fv = 1;
          m_fd = m_acc & m_mask;
          if (continuous && ch_mask != 0) m_launch();
          else m_busy = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".s"},     32'(s),            32'(m_ch));
    chk({pfx, ".busy"},  32'(busy),         32'(m_busy));
    chk({pfx, ".sv"},    32'(sample_valid), 32'(m_sv));
    chk({pfx, ".sch"},   32'(sample_ch),    32'(m_sch));
    chk({pfx, ".sd"},    32'(sample_data),  32'(m_sd));
    chk({pfx, ".fv"},    32'(frame_valid),  32'(m_fv));
    chk({pfx, ".fd"},    32'(frame_data),   32'(m_fd));
  endtask

  bit       pat_mode;
  bit [3:0] pat;

  task automatic step(input string pfx);
    @(posedge clk);
    m_edge();
    #1;
    check_all(pfx);
    if (pat_mode) y_in = pat[m_ch];
  endtask

  task automatic wait_frame(input string pfx, output bit got);
    got = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      step(pfx);
      if (frame_valid) got = 1;
    end
    chk({pfx, ".timeout"}, 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #2;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit       got;
  int       frames, sv_cnt;
  bit [3:0] fd_prev;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; continuous = 0;
    ch_mask = 0; settle = 0; y_in = 0; pat_mode = 0; pat = 0;
    m_reset();
    #2;
    check_all("rst0");
    do_reset();
    step("idle");

    // Full mask, no settle
    pat_mode = 1; pat = 4'b1101;
    start = 1; ch_mask = 4'b1111; settle = 0; y_in = pat[0];
    step("s1");
    start = 0;
    sv_cnt = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step("s1");
      if (sample_valid) sv_cnt++;
      if (frame_valid) got = 1;
    end
    chk("s1.frame", 32'(got), 32'd1);
    chk("s1.nsamp", 32'(sv_cnt), 32'd4);
    chk("s1.fdata", 32'(frame_data), 32'hD);
    step("s1");

    // Sparse mask with settle
    pat = 4'b1111;
    start = 1; ch_mask = 4'b1010; settle = 2; y_in = 1;
    step("s2");
    start = 0;
    chk("s2.s_first", 32'(s), 32'd1);
    wait_frame("s2", got);
    chk("s2.fdata", 32'(frame_data), 32'hA);
    chk("s2.lastch", 32'(sample_ch), 32'd3);

    // Empty mask ignored; start during a frame ignored
    start = 1; ch_mask = 0;
    step("s3"); step("s3");
    chk("s3.busy", 32'(busy), 32'd0);
    ch_mask = 4'b0100; settle = 3;
    step("s3");
    ch_mask = 4'b0011; settle = 0;
    step("s3"); step("s3");
    start = 0;
    wait_frame("s3", got);
    chk("s3.fdata", 32'(frame_data), 32'h4);

    // Continuous single-channel frames
    continuous = 1; start = 1; ch_mask = 4'b0001; settle = 1;
    step("s4");
    start = 0;
    frames = 0;
    for (int k = 0; k < 8; k++) begin
      step("s4");
      if (frame_valid) frames++;
      chk("s4.busy", 32'(busy), 32'd1);
    end
    chk("s4.frames", 32'(frames), 32'd4);
    continuous = 0;
    frames = 0;
    for (int k = 0; k < 6; k++) begin
      step("s4b");
      if (frame_valid) frames++;
    end
    chk("s4.tail", 32'(frames), 32'd1);
    chk("s4.idle", 32'(busy), 32'd0);

    // Abort on a capture edge
    fd_prev = frame_data;
    start = 1; ch_mask = 4'b0010; settle = 0; pat = 4'b0000;
    step("s5");
    start = 0; abort = 1;
    step("s5");
    abort = 0;
    chk("s5.sv", 32'(sample_valid), 32'd0);
    chk("s5.fd", 32'(frame_data), 32'(fd_prev));
    step("s5"); step("s5");

    // Reset mid-settle
    start = 1; ch_mask = 4'b1000; settle = 6;
    step("s6");
    start = 0;
    step("s6");
    do_reset();
    for (int k = 0; k < 4; k++) step("s6post");

    // Randomized traffic
    pat_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      ch_mask    = 4'($urandom_range(0, 15));
      settle     = ($urandom_range(0, 3) == 0) ? SETTLE_W'($urandom_range(0, 15))
                                               : SETTLE_W'($urandom_range(0, 2));
      y_in       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 500) == 0) do_reset();
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_W, default 4, width of the settle-count input.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous frame cancel.
REQ-006 SHALL have port continuous  input  1  when high, a new frame starts automatically after each completed frame.
REQ-007 SHALL have port ch_mask  input  4  channel enable; bit i enables mux input i (a=0, b=1, c=2, d=3).
REQ-008 SHALL have port settle  input  SETTLE_W  extra cycles to wait after each select change before capture.
REQ-009 SHALL have port y_in  input  1  4:1 mux output being scanned.
REQ-010 SHALL have port s  output  2  registered select driven to the 4:1 mux.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port sample_valid  output  1  one-cycle strobe per captured channel.
REQ-013 SHALL have port sample_ch  output  2  channel index of the current capture.
REQ-014 SHALL have port sample_data  output  1  captured y_in value.
REQ-015 SHALL have port frame_valid  output  1  one-cycle strobe on frame completion.
REQ-016 SHALL have port frame_data  output  4  completed frame; bit i = captured value of channel i, 0 if disabled.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE and CAPTURE; every output is registered.
REQ-018 In IDLE, start=1 with ch_mask!=0 at edge E0 SHALL latch ch_mask and settle, set s to the lowest enabled channel, clear the internal frame accumulator, set busy=1 and enter SETTLE.
REQ-019 In IDLE, start=1 with ch_mask==0 SHALL be ignored: no state change and no strobes.
REQ-020 start, ch_mask and settle changes while busy=1 SHALL be ignored until the next frame is latched.
REQ-021 After every change of s, y_in SHALL be captured at exactly the (settle+1)th following edge; settle=0 means capture on the next edge.
REQ-022 The settle counter SHALL load the latched settle value on each s change and decrement to 0 without wrap.
REQ-023 At a capture edge, the block SHALL write y_in to accumulator bit s, drive sample_ch=s and sample_data=y_in, and assert sample_valid for exactly the following cycle.
REQ-024 At a capture edge with a higher enabled channel remaining, s SHALL advance to the next higher enabled channel, skipping disabled channels with no dead cycles.
REQ-025 At the capture edge of the highest enabled channel, the block SHALL load frame_data from the accumulator (disabled bits 0) and assert frame_valid for one cycle, coincident with the last sample_valid.
REQ-026 At frame end with continuous=0, the block SHALL return to IDLE with busy=0 in the same cycle as frame_valid=1; s SHALL hold its last value.
REQ-027 At frame end with continuous=1, the block SHALL re-latch ch_mask and settle at that same edge and start a new frame with no idle cycle; if the new ch_mask==0 it SHALL go to IDLE instead.
REQ-028 continuous sampled low mid-frame SHALL let the current frame complete, then go to IDLE.
REQ-029 abort=1 SHALL return the block to IDLE at that edge with busy=0, no sample_valid or frame_valid for that edge, and frame_data unchanged; abort takes priority over a simultaneous capture.
REQ-030 frame_data SHALL hold its value between frame_valid strobes.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, s=0, busy=0, sample_valid=0, sample_ch=0, sample_data=0, frame_valid=0 and frame_data=0, including mid-frame; no strobe SHALL follow reset release without a new start.

Verification
REQ-032 Scenario: mask=4'b1111, settle=0, y_in=1,0,1,1 on ch 0..3, start pulse -> s=0,1,2,3 for 1 cycle each; 4 sample_valid strobes; frame_valid with frame_data=4'b1101.
REQ-033 Scenario: mask=4'b1010, settle=2 -> s=1 for 3 cycles then s=3 for 3 cycles; sample_ch=1,3; frame_data bits 0 and 2 = 0.
REQ-034 Scenario: mask=0, start pulse -> busy stays 0, no strobes; then start during a frame -> ignored.
REQ-035 Scenario: continuous=1, mask=4'b0001, settle=1 -> frame_valid every 2 cycles with busy held at 1; continuous dropped -> exactly one more frame, then IDLE.
REQ-036 Scenario: abort on a capture edge -> IDLE, no strobes, frame_data keeps its prior value.
REQ-037 Scenario: rst_n low mid-SETTLE -> all outputs 0 immediately, with no clock edge required.
